// File: rtl/pe_depkt_pkg.sv
// Shared types, marker codes and packet field offsets for the
// PE-side depacketizer.
package pe_depkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DONE
  } state_e;

  localparam logic [2:0] MEM_SRC_DEF  = 3'b100;
  localparam logic [2:0] DONE_SRC_DEF = 3'b011;
  localparam logic [7:0] DONE_MARK    = 8'hFF;

  // Layout from LSB: ifmap entries, filter entries, src, dst.
  function automatic int ifmap_lsb();
    return 0;
  endfunction

  function automatic int filt_lsb(
    input int i,
    input int n_ifmap,
    input int ifmap_w,
    input int filt_w
  );
    return ifmap_lsb() + n_ifmap * ifmap_w + i * filt_w;
  endfunction

  function automatic int src_lsb(
    input int n_ifmap,
    input int ifmap_w,
    input int n_filt,
    input int filt_w
  );
    return filt_lsb(n_filt, n_ifmap, ifmap_w, filt_w);
  endfunction

  function automatic int dst_lsb(
    input int n_ifmap,
    input int ifmap_w,
    input int n_filt,
    input int filt_w,
    input int src_w
  );
    return src_lsb(n_ifmap, ifmap_w, n_filt, filt_w) + src_w;
  endfunction

endpackage

// File: rtl/pe_depkt_skid.sv
// One-entry valid/ready buffer in front of the depacketizer FSM;
// passes straight through while empty.
module pe_depkt_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_s_valid,
  output logic         o_s_ready,
  input  logic [W-1:0] i_s_data,
  output logic         o_m_valid,
  input  logic         i_m_ready,
  output logic [W-1:0] o_m_data
);

  logic         r_full;
  logic [W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (r_full) begin
      if (i_m_ready) r_full <= 1'b0;
    end else if (i_s_valid && !i_m_ready) begin
      r_full <= 1'b1;
      r_data <= i_s_data;
    end
  end

  assign o_s_ready = !r_full;
  assign o_m_valid = r_full || i_s_valid;
  assign o_m_data  = r_full ? r_data : i_s_data;

endmodule

// File: rtl/pe_depacketizer_sync.sv
// PE-side NoC depacketizer: header decode, scratchpad streaming,
// start/done handshakes. PE_DEPKT_SKID_EN adds a one-entry input buffer.
module pe_depacketizer_sync
  import pe_depkt_pkg::*;
#(
  parameter int N_IFMAP = 5,
  parameter int IFMAP_W = 1,
  parameter int N_FILT  = 3,
  parameter int FILT_W  = 8,
  parameter int SRC_W   = 3,
  parameter int DST_W   = 3,
  parameter logic [DST_W-1:0] PE_ADDR  = '0,
  parameter logic [SRC_W-1:0] MEM_SRC  = SRC_W'(MEM_SRC_DEF),
  parameter logic [SRC_W-1:0] DONE_SRC = SRC_W'(DONE_SRC_DEF),
  parameter bit DONE_FWD = 1'b0,
  parameter int WIDTH_PACKET =
    DST_W + SRC_W + N_FILT * FILT_W + N_IFMAP * IFMAP_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pkt_valid,
  output logic                       pkt_ready,
  input  logic [WIDTH_PACKET-1:0]    pkt_data,
  output logic                       ifmap_we,
  output logic [$clog2(N_IFMAP)-1:0] ifmap_waddr,
  output logic [IFMAP_W-1:0]         ifmap_wdata,
  output logic                       filt_we,
  output logic [$clog2(N_FILT)-1:0]  filt_waddr,
  output logic [FILT_W-1:0]          filt_wdata,
  input  logic                       filt_reload,
  output logic                       filt_loaded,
  output logic                       start_valid,
  input  logic                       start_ready,
  output logic                       done_valid,
  input  logic                       done_ready
);

  localparam int LMAX = (N_IFMAP > N_FILT) ? N_IFMAP : N_FILT;
  localparam int CW   = $clog2(LMAX + 1);
  localparam int IAW  = $clog2(N_IFMAP);
  localparam int FAW  = $clog2(N_FILT);
  localparam int IFM_LSB = ifmap_lsb();
  localparam int SRC_LSB =
    src_lsb(N_IFMAP, IFMAP_W, N_FILT, FILT_W);
  localparam int PW = SRC_LSB;

  state_e r_state;
  state_e w_state_nx;

  logic [PW-1:0] r_pkt;
  logic [CW-1:0] r_k;
  logic [CW-1:0] w_k_nx;
  logic          r_filt_wr;
  logic          r_filt_loaded;
  logic          r_rl_seen;

  logic                    w_in_valid;
  logic                    w_in_ready;
  logic [WIDTH_PACKET-1:0] w_in_data;
  logic                    w_accept;
  logic [SRC_W-1:0]        w_src;
  logic                    w_is_done;
  logic                    w_is_mem;
  logic                    w_wr_filt;
  logic                    w_last;

`ifdef PE_DEPKT_SKID_EN
  pe_depkt_skid #(
    .W(WIDTH_PACKET)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_s_valid (pkt_valid),
    .o_s_ready (pkt_ready),
    .i_s_data  (pkt_data),
    .o_m_valid (w_in_valid),
    .i_m_ready (w_in_ready),
    .o_m_data  (w_in_data)
  );
`else
  assign w_in_valid = pkt_valid;
  assign w_in_data  = pkt_data;
  assign pkt_ready  = w_in_ready;
`endif

  // With the buffer, the next packet launches on the closing handshake.
  always_comb begin
    w_in_ready = (r_state == ST_IDLE);
`ifdef PE_DEPKT_SKID_EN
    if (r_state == ST_START && start_ready) w_in_ready = 1'b1;
    if (r_state == ST_DONE && done_ready)   w_in_ready = 1'b1;
`endif
  end

  assign w_accept  = w_in_valid && w_in_ready;
  assign w_src     = w_in_data[SRC_LSB +: SRC_W];
  assign w_is_done = DONE_FWD && (w_src == DONE_SRC) &&
                     (w_in_data[7:0] == DONE_MARK);
  assign w_is_mem  = (w_src == MEM_SRC);
  assign w_wr_filt = w_is_mem && (!r_filt_loaded || filt_reload);
  assign w_last    = (r_k == (r_filt_wr ? CW'(LMAX - 1)
                                        : CW'(N_IFMAP - 1)));

  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    unique case (r_state)
      ST_IDLE: w_state_nx = ST_IDLE;
      ST_LOAD: begin
        if (w_last) begin
          w_state_nx = ST_START;
          w_k_nx     = '0;
        end else begin
          w_k_nx = r_k + CW'(1);
        end
      end
      ST_START: if (start_ready) w_state_nx = ST_IDLE;
      ST_DONE:  if (done_ready)  w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
    if (w_accept) begin
      w_state_nx = w_is_done ? ST_DONE : ST_LOAD;
      w_k_nx     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_k           <= '0;
      r_pkt         <= '0;
      r_filt_wr     <= 1'b0;
      r_filt_loaded <= 1'b0;
      r_rl_seen     <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_k     <= w_k_nx;
      if (w_accept) begin
        r_pkt     <= w_in_data[PW-1:0];
        r_filt_wr <= w_wr_filt && !w_is_done;
        r_rl_seen <= 1'b0;
      end else if (filt_reload) begin
        r_rl_seen <= 1'b1;
      end
      // A reload seen mid-LOAD must survive this packet's completion.
      if (filt_reload) begin
        r_filt_loaded <= 1'b0;
      end else if (r_state == ST_LOAD && w_last &&
                   r_filt_wr && !r_rl_seen) begin
        r_filt_loaded <= 1'b1;
      end
    end
  end

  always_comb begin
    ifmap_we    = 1'b0;
    ifmap_waddr = '0;
    ifmap_wdata = '0;
    filt_we     = 1'b0;
    filt_waddr  = '0;
    filt_wdata  = '0;
    if (r_state == ST_LOAD) begin
      for (int i = 0; i < N_IFMAP; i++) begin
        if (r_k == CW'(i)) begin
          ifmap_we    = 1'b1;
          ifmap_waddr = IAW'(i);
          ifmap_wdata = r_pkt[IFM_LSB + i * IFMAP_W +: IFMAP_W];
        end
      end
      for (int i = 0; i < N_FILT; i++) begin
        if (r_filt_wr && r_k == CW'(i)) begin
          filt_we    = 1'b1;
          filt_waddr = FAW'(i);
          filt_wdata =
            r_pkt[filt_lsb(i, N_IFMAP, IFMAP_W, FILT_W) +: FILT_W];
        end
      end
    end
  end

  assign start_valid = (r_state == ST_START);
  assign done_valid  = (r_state == ST_DONE);
  assign filt_loaded = r_filt_loaded;

endmodule
